// File: rtl/mod_dec_invshifter_if.sv
// Byte-stream and parallel-block bundle for the decryption-path InvShiftRows stage.
// The producer/consumer side is the master; the shifter itself is the slave.
interface mod_dec_invshifter_if #(
   parameter int N = 16,
   parameter int W = 8
);
   logic [W-1:0]        inp;
   logic                wr_en;
   logic                in_ready;
   logic [W-1:0]        outp;
   logic                outp_valid;
   logic                rd_en;
   logic [N-1:0][W-1:0] outp_blk;
   logic                blk_valid;
   logic                done;

   modport master (
      output inp, wr_en, rd_en,
      input  in_ready, outp, outp_valid, outp_blk, blk_valid, done
   );

   modport slave (
      input  inp, wr_en, rd_en,
      output in_ready, outp, outp_valid, outp_blk, blk_valid, done
   );
endinterface

// File: rtl/mod_dec_invshifter.sv
// Decryption-path InvShiftRows: serial byte load, inverse row rotation on the
// load->output buffer transfer, serial drain plus a parallel view of the block.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_EMPTY | output buffer holds nothing undrained; waits for a full load buffer
//   S_SEND  | output buffer valid; streams obuf[out_cnt] until byte 15 is consumed
module mod_dec_invshifter #(
   parameter int N = 16,
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   mod_dec_invshifter_if.slave   bus
);
   localparam int           CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_SEND  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N-1:0][W-1:0] r_lbuf;
   logic [N-1:0][W-1:0] r_obuf;
   logic [N-1:0][W-1:0] w_shift;
   logic [CW-1:0]       r_in_cnt;
   logic [CW-1:0]       r_out_cnt;
   logic                r_ld_full;
   logic                r_done;
   logic                w_in_ready;
   logic                w_wr_acc;
   logic                w_rd_acc;
   logic                w_last_rd;
   logic                w_xfer;
   logic                w_outp_valid;

   // Reset is active-high despite the port name; input is refused while it is held.
   assign w_in_ready = !r_ld_full && !resetn;
   assign w_wr_acc   = bus.wr_en && w_in_ready;
   assign w_rd_acc   = (r_state == S_SEND) && bus.rd_en;
   assign w_last_rd  = w_rd_acc && (r_out_cnt == LAST);
   assign w_xfer     = r_ld_full && (r_state == S_EMPTY);

   // Row r of the output is row r of the load buffer rotated right by r.
   for (genvar gr = 0; gr < 4; gr++) begin : g_row
      for (genvar gc = 0; gc < 4; gc++) begin : g_col
         assign w_shift[gr*4 + gc] = r_lbuf[gr*4 + ((gc - gr + 4) % 4)];
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_outp_valid = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_xfer) begin
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            w_outp_valid = 1'b1;
            if (w_last_rd) begin
               w_state_nxt = S_EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_lbuf    <= '0;
         r_obuf    <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_ld_full <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_lbuf[r_in_cnt] <= bus.inp;
            r_in_cnt         <= r_in_cnt + CW'(1);
         end

         // A full load buffer blocks input, so setting and clearing never collide.
         if (w_wr_acc && (r_in_cnt == LAST)) begin
            r_ld_full <= 1'b1;
         end else if (w_xfer) begin
            r_ld_full <= 1'b0;
         end

         if (w_xfer) begin
            r_obuf    <= w_shift;
            r_out_cnt <= '0;
         end else if (w_rd_acc) begin
            r_out_cnt <= r_out_cnt + CW'(1);
         end

         r_done <= w_last_rd;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.outp       = r_obuf[r_out_cnt];
   assign bus.outp_valid = w_outp_valid;
   assign bus.outp_blk   = r_obuf;
   assign bus.blk_valid  = w_outp_valid;
   assign bus.done       = r_done;
endmodule

// File: tb/tb_mod_dec_invshifter.sv
// Bench for mod_dec_invshifter: per-cycle scoreboard built from block-level
// queues, plus fixed-pattern, round-trip, backpressure, reset and random scenarios.
module tb_mod_dec_invshifter;
   logic clk    = 1'b0;
   logic resetn = 1'b1;

   mod_dec_invshifter_if #(.N(16), .W(8)) bus ();

   mod_dec_invshifter #(.N(16), .W(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc_no = 0;

   // reference model state
   logic [7:0]   m_ld[$];
   bit           m_ld_full = 1'b0;
   bit           m_send    = 1'b0;
   bit           m_done    = 1'b0;
   int           m_oidx    = 0;
   logic [127:0] m_ob      = '0;
   bit           m_hold    = 1'b0;
   logic [7:0]   m_hold_val;

   logic [7:0]   got[$];
   bit           g_acc;
   int           n_done;
   int           first_valid;

   logic [7:0]   t1_exp [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                                 8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};
   // FIPS-197 round-1 state after SubBytes, listed column by column
   logic [7:0]   fips   [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                 8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_no);
      else n_pass++;
   endtask

   // Row r rotated right by r (byte i lives at bits i*8).
   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            res[(r*4 + (c + r) % 4)*8 +: 8] = s[(r*4 + c)*8 +: 8];
      return res;
   endfunction

   // Encryption-side ShiftRows: row r rotated left by r.
   function automatic logic [127:0] fwd_shift(input logic [127:0] s);
      logic [127:0] res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            res[(r*4 + c)*8 +: 8] = s[(r*4 + (c + r) % 4)*8 +: 8];
      return res;
   endfunction

   task automatic cyc(input bit rst, input bit wr, input logic [7:0] d, input bit rd);
      logic [127:0] blk;
      bit           old_send;
      bit           old_full;
      bit           nd;
      @(negedge clk);
      resetn    = rst;
      bus.wr_en = wr;
      bus.inp   = d;
      bus.rd_en = rd;
      #1;
      cyc_no++;
      chk("in_ready",   128'(bus.in_ready),   128'(!rst && !m_ld_full));
      chk("outp_valid", 128'(bus.outp_valid), 128'(m_send));
      chk("blk_valid",  128'(bus.blk_valid),  128'(m_send));
      chk("done",       128'(bus.done),       128'(m_done));
      if (m_send) begin
         chk("outp",     128'(bus.outp), 128'(m_ob[m_oidx*8 +: 8]));
         chk("outp_blk", bus.outp_blk,   m_ob);
      end
      if (m_hold) chk("hold", 128'(bus.outp), 128'(m_hold_val));
      g_acc = wr && bus.in_ready;
      if (bus.done) n_done++;
      if (bus.outp_valid && first_valid < 0) first_valid = cyc_no;
      m_hold     = !rst && m_send && !rd;
      m_hold_val = bus.outp;
      if (rst) begin
         m_ld.delete();
         m_ld_full = 1'b0;
         m_send    = 1'b0;
         m_done    = 1'b0;
         m_oidx    = 0;
         m_ob      = '0;
      end else begin
         old_send = m_send;
         old_full = m_ld_full;
         nd       = 1'b0;
         if (rd && old_send) begin
            got.push_back(bus.outp);
            if (m_oidx == 15) begin
               m_send = 1'b0;
               m_oidx = 0;
               nd     = 1'b1;
            end else begin
               m_oidx++;
            end
         end
         if (wr && !old_full) begin
            m_ld.push_back(d);
            if (m_ld.size() == 16) m_ld_full = 1'b1;
         end
         if (old_full && !old_send) begin
            blk = '0;
            for (int i = 0; i < 16; i++) blk[i*8 +: 8] = m_ld[i];
            m_ob = inv_shift(blk);
            m_ld.delete();
            m_ld_full = 1'b0;
            m_send    = 1'b1;
            m_oidx    = 0;
         end
         m_done = nd;
      end
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [127:0] orig;
      logic [127:0] enc;
      logic [7:0]   src[$];
      logic [7:0]   exp_q[$];
      int           last_acc;
      int           idx;
      int           vcnt;
      int           vfirst;
      int           vlast;
      int           budget;
      logic [127:0] rb;

      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.inp   = 8'h00;
      repeat (2) @(posedge clk);

      // fixed pattern, rd_en held
      do_reset();
      got.delete(); n_done = 0; first_valid = -1; last_acc = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'(i), 1'b1);
         if (g_acc) last_acc = cyc_no;
      end
      repeat (24) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t1_latency", 128'(first_valid - last_acc), 128'(2));
      chk("t1_len", 128'(got.size()), 128'(16));
      for (int i = 0; i < 16 && i < got.size(); i++) chk("t1_byte", 128'(got[i]), 128'(t1_exp[i]));
      chk("t1_done", 128'(n_done), 128'(1));

      // round trip through the encryption-side shifter
      do_reset();
      orig = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            orig[(r*4 + c)*8 +: 8] = fips[c*4 + r];
      enc = fwd_shift(orig);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, enc[i*8 +: 8], 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("rt_blk", bus.outp_blk, orig);
      repeat (20) cyc(1'b0, 1'b0, 8'h00, 1'b1);

      // backpressure: two blocks loaded with rd_en low
      do_reset();
      got.delete(); idx = 0; budget = 0;
      while (idx < 32 && budget < 200) begin
         cyc(1'b0, 1'b1, 8'(idx), 1'b0);
         if (g_acc) idx++;
         budget++;
      end
      chk("bp_loaded", 128'(idx), 128'(32));
      repeat (3) cyc(1'b0, 1'b1, 8'hEE, 1'b0);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      vcnt = 0; vfirst = -1; vlast = -1;
      repeat (45) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         if (bus.outp_valid) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc_no;
            vlast = cyc_no;
         end
      end
      chk("bp_len", 128'(got.size()), 128'(32));
      for (int i = 0; i < 32 && i < got.size(); i++)
         chk("bp_byte", 128'(got[i]), 128'(t1_exp[i % 16] + 8'((i / 16) * 16)));
      chk("bp_valid_cnt", 128'(vcnt), 128'(32));
      chk("bp_span", 128'(vlast - vfirst + 1), 128'(33));

      // reset mid-block: 7 bytes in, 5 bytes out
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i), 1'b1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 8'(8'h55 + i), 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("rst_outp",       128'(bus.outp),       128'(0));
      chk("rst_outp_blk",   bus.outp_blk,         128'(0));
      chk("rst_outp_valid", 128'(bus.outp_valid), 128'(0));
      chk("rst_blk_valid",  128'(bus.blk_valid),  128'(0));
      chk("rst_done",       128'(bus.done),       128'(0));
      chk("rst_in_ready",   128'(bus.in_ready),   128'(1));
      got.delete();
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
      repeat (24) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst_len", 128'(got.size()), 128'(16));
      for (int i = 0; i < 16 && i < got.size(); i++)
         chk("rst_byte", 128'(got[i]), 128'(t1_exp[i] + 8'h60));

      // idle: rd_en with nothing loaded, garbage on inp with wr_en low
      got.delete(); n_done = 0; first_valid = -1;
      repeat (8) cyc(1'b0, 1'b0, 8'($urandom), 1'b1);
      chk("idle_valid", 128'(first_valid), 128'(-1));
      chk("idle_done",  128'(n_done), 128'(0));
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h70 + i), 1'b1);
      repeat (24) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("idle_len", 128'(got.size()), 128'(16));
      for (int i = 0; i < 16 && i < got.size(); i++)
         chk("idle_byte", 128'(got[i]), 128'(t1_exp[i] + 8'h70));

      // random wr_en/rd_en gaps over four random blocks
      got.delete(); src.delete(); exp_q.delete();
      for (int b = 0; b < 4; b++) begin
         rb = '0;
         for (int i = 0; i < 16; i++) begin
            rb[i*8 +: 8] = 8'($urandom);
            src.push_back(rb[i*8 +: 8]);
         end
         rb = inv_shift(rb);
         for (int i = 0; i < 16; i++) exp_q.push_back(rb[i*8 +: 8]);
      end
      budget = 0;
      while (got.size() < 64 && budget < 3000) begin
         if (src.size() > 0 && ($urandom % 2) == 1) cyc(1'b0, 1'b1, src[0], 1'($urandom % 2));
         else cyc(1'b0, 1'b0, 8'($urandom), 1'($urandom % 2));
         if (g_acc) void'(src.pop_front());
         budget++;
      end
      chk("rnd_len", 128'(got.size()), 128'(64));
      for (int i = 0; i < 64 && i < got.size(); i++) chk("rnd_byte", 128'(got[i]), 128'(exp_q[i]));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
